// File: rtl/seq_sub_32.sv
// ---------------------------------------------------------------------------
// seq_sub_32 -- multi-cycle 32-bit two's-complement subtractor (a - b)
//
// The difference is formed as a + ~b + 1 in four 8-bit slices, least
// significant slice first, one slice per clock. The carry between slices is
// held in a register, so the longest combinational carry path is one 8-bit
// ripple rather than the full 32 bits. This suits ALU paths where a 32-bit
// single-cycle ripple does not close timing.
//
// Transaction timing:
//   E0      : accept edge (IDLE, in_valid = 1); operands captured
//   E1..E4  : slices 0..3 computed; flags registered on E4
//   after E4: out_valid = 1 until an edge with out_ready = 1
//   Minimum issue interval is 6 cycles.
//
// Build option:
//   SEQ_SUB_SATURATE_EN -- when defined, a signed overflow clamps the result
//                          to 0x80000000 (a negative) or 0x7FFFFFFF (a
//                          non-negative). borrow/overflow still report the
//                          raw condition; zero reflects the clamped value.
//                          When undefined the result wraps modulo 2^32.
//
// Ports:
//   clock      in   1   system clock, rising edge active
//   reset      in   1   asynchronous, active-high reset
//   in_valid   in   1   operands a/b present
//   in_ready   out  1   block can accept operands (IDLE only)
//   a          in   32  minuend
//   b          in   32  subtrahend
//   out_valid  out  1   result and flags valid
//   out_ready  in   1   consumer accepts the result
//   result     out  32  a - b (modulo 2^32, or clamped when saturating)
//   borrow     out  1   unsigned borrow, 1 when a < b unsigned
//   overflow   out  1   signed overflow
//   zero       out  1   result == 0
// ---------------------------------------------------------------------------
module seq_sub_32 #(
    parameter int SLICE_W    = 8,   // only 8 is supported
    parameter int NUM_SLICES = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [SLICE_W*NUM_SLICES-1:0] a,
    input  logic [SLICE_W*NUM_SLICES-1:0] b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [SLICE_W*NUM_SLICES-1:0] result,
    output logic                          borrow,
    output logic                          overflow,
    output logic                          zero
);

    localparam int DATA_W = SLICE_W * NUM_SLICES;
    localparam int CNT_W  = $clog2(NUM_SLICES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;        // index of the slice computed next
    logic                carry_q;      // carry into the current slice
    logic [DATA_W-1:0]   a_q;          // captured minuend
    logic [DATA_W-1:0]   nb_q;         // captured, inverted subtrahend
    logic [DATA_W-1:0]   result_q;
    logic                borrow_q;
    logic                overflow_q;
    logic                zero_q;
    logic                out_valid_q;
    logic                in_ready_q;

    // -----------------------------------------------------------------------
    // One slice of the ripple adder, selected by the slice counter
    // -----------------------------------------------------------------------
    logic [SLICE_W-1:0]  a_slice;
    logic [SLICE_W-1:0]  nb_slice;
    logic [SLICE_W-1:0]  slice_sum;
    logic                slice_cout;
    logic                slice_cin_msb;  // carry into the slice's top bit
    logic                rip_c;
    int                  slice_lsb;

    // NOTE: every variable written in an always_comb gets a default at the
    // top, so no path can leave it unassigned and infer a latch.
    always_comb begin
        slice_lsb     = int'(cnt_q) * SLICE_W;
        a_slice       = a_q[slice_lsb +: SLICE_W];
        nb_slice      = nb_q[slice_lsb +: SLICE_W];
        slice_sum     = '0;
        slice_cin_msb = 1'b0;
        // NOTE: blocking assignments here model the ripple in order; each
        // bit must see the carry just produced by the bit below it.
        rip_c         = carry_q;
        for (int i = 0; i < SLICE_W; i++) begin
            if (i == SLICE_W - 1) begin
                slice_cin_msb = rip_c;
            end
            slice_sum[i] = a_slice[i] ^ nb_slice[i] ^ rip_c;
            rip_c        = (a_slice[i] & nb_slice[i]) |
                           (a_slice[i] & rip_c)       |
                           (nb_slice[i] & rip_c);
        end
        slice_cout = rip_c;
    end

    // -----------------------------------------------------------------------
    // Next-state values used on the final slice edge
    // -----------------------------------------------------------------------
    logic               last_slice;
    logic [CNT_W-1:0]   cnt_d;
    logic [DATA_W-1:0]  raw_d;       // full wrapped difference
    logic [DATA_W-1:0]  result_d;    // value written on the final edge
    logic               overflow_d;
    logic               borrow_d;

    always_comb begin
        last_slice = (cnt_q == CNT_W'(NUM_SLICES - 1));
        cnt_d      = cnt_q + CNT_W'(1);
        // Lower slices are already in result_q; the top slice is in flight.
        raw_d      = {slice_sum, result_q[DATA_W-SLICE_W-1:0]};
        // On the top slice, carry into / out of the top bit are bit 31's.
        overflow_d = slice_cin_msb ^ slice_cout;
        borrow_d   = ~slice_cout;
`ifdef SEQ_SUB_SATURATE_EN
        if (overflow_d) begin
            // Overflow implies opposite operand signs; a's sign picks the rail.
            result_d = a_q[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                     : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            result_d = raw_d;
        end
`else
        result_d = raw_d;
`endif
    end

    // -----------------------------------------------------------------------
    // Control FSM and datapath registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            // NOTE: the operand registers are reset too, so a transaction
            // cut short by reset leaves nothing behind.
            a_q         <= '0;
            nb_q        <= '0;
            result_q    <= '0;
            borrow_q    <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        nb_q       <= ~b;
                        carry_q    <= 1'b1;  // the +1 of a + ~b + 1
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_RUN;
                    end
                end

                S_RUN: begin
                    carry_q <= slice_cout;
                    cnt_q   <= cnt_d;
                    if (last_slice) begin
                        result_q    <= result_d;
                        borrow_q    <= borrow_d;
                        overflow_q  <= overflow_d;
                        zero_q      <= (result_d == '0);
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        result_q[slice_lsb +: SLICE_W] <= slice_sum;
                    end
                end

                S_DONE: begin
                    // in_ready stays low this cycle, so no accept can coincide
                    // with the output handshake.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end

                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign borrow    = borrow_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;

endmodule
